inert_intf_mc: RTL
==================

Name: inert_intf_mc

Overview:
- Parametrised successor to the single-pitch inertial interface.
- Sequences a configurable table of init writes to the inertial sensor after reset, then on each data-ready interrupt reads NUM_CH 16-bit registers (low byte then high byte) via an external SPI master (SPI_mnrch).
- Assembles and optionally spike-filters the words, then pulses vld.
- Adds what the previous block lacked: a missing-`done` error flag and an INT-timeout flag for sensor-health monitoring. Sits between SPI_mnrch and the integrator/balance logic.

Parameters:
- NUM_CH, 2, number of 16-bit channels read per INT (1..4).
- CH_ADDR, {8'h2C,8'h22}, packed NUM_CH×8 low-byte register addresses; ch i at CH_ADDR[8i+:8]; high byte at addr+1.
- NUM_INIT, 4, number of init commands (1..8).
- INIT_CMDS, {16'h1460,16'h1150,16'h1053,16'h0D02}, packed NUM_INIT×16; cmd j at [16j+:16], issued j=0 first.
- INIT_WAIT_W, 16, power-up wait = 2^INIT_WAIT_W cycles.
- GAP_W, 10, SPI transaction slot = 2^GAP_W cycles.
- INT_TO_W, 20, INT timeout = 2^INT_TO_W cycles in WAIT.
- FILT_MASK, 'b01, per-channel spike-filter enable (NUM_CH bits).
- FILT_LIM, 16'h1F00, signed filter magnitude limit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- INT  in  1  sensor data-ready, asynchronous, level
- done  in  1  SPI_mnrch transaction complete (1-cycle pulse)
- rd_data  in  16  SPI_mnrch read data; byte in [7:0]
- wrt  out  1  start SPI transaction (1-cycle pulse)
- cmd  out  16  SPI command word, valid when wrt=1
- data  out  NUM_CH×16  channel words after filter, ch i at [16i+:16]
- vld  out  1  1-cycle pulse when new data set available
- init_done  out  1  high once last init cmd issued
- spi_err  out  1  sticky: a read slot expired without done
- int_to  out  1  INT absent for 2^INT_TO_W cycles in WAIT

Behaviour:
- Reset: state PWR, timer=0, all byte regs=0 (data=0), vld=0, wrt=0, init_done=0, spi_err=0, int_to=0. Async reset mid-operation aborts any transaction and replays the full init sequence.
- INT synchronised by two flops; only INT_ff2 is used.
- Single up-counter timer, width = max(INIT_WAIT_W, GAP_W, INT_TO_W). Cleared in every cycle wrt=1, else increments. GAP = timer[GAP_W-1:0] all ones.
- States: PWR, INIT, WAIT, READ. Index j (init) / k (byte 0..2·NUM_CH-1).
- PWR: when timer[INIT_WAIT_W-1:0] is all ones, wrt with cmd=INIT_CMDS[0], j=1. If NUM_INIT=1, go to WAIT and set init_done; else go to INIT.
- INIT: on GAP, wrt with cmd=INIT_CMDS[j], j++. After the last cmd, set init_done and go to WAIT.
- WAIT: if INT_ff2, then wrt with cmd = {1'b1, CH_ADDR[0][6:0], 8'h00}, k=0, clear int_to, go to READ. Else, when timer[INT_TO_W-1:0] is all ones, set int_to (stays set until next INT).
- READ k:
  - done → capture rd_data[7:0] into byte reg k (even k = low, odd k = high of channel k/2).
  - On GAP, if no done was seen this slot, set spi_err (byte reg keeps old value).
  - On GAP with k<2·NUM_CH-1: wrt with cmd = {1'b1, addr[6:0], 8'h00}, where addr = CH_ADDR[k'/2] + (k' odd), k'=k+1; k++.
  - On GAP with k=2·NUM_CH-1: vld=1, go to WAIT.
- done and GAP in the same cycle: byte captured, no spi_err.
- Timing:
  - First read wrt occurs in the same cycle INT_ff2 is seen high.
  - Read wrt m occurs m·2^GAP_W cycles after the first read wrt.
  - vld occurs 2·NUM_CH·2^GAP_W cycles after the first read wrt.
- INT during PWR/INIT/READ is ignored (no queuing). If INT is still high on return to WAIT, the next read starts the following cycle.
- Filter (combinational on assembled word w): if FILT_MASK[i] and (w > FILT_LIM or w < -FILT_LIM), signed compare, output 16'h0000; else w. Values equal to ±FILT_LIM pass.
- Outside wrt cycles, cmd drives 16'h0000.

Test Plan:
- Init sequence (INIT_WAIT_W=6, GAP_W=4): release reset → wrt 0x0D02 at cycle 63, then 0x1053/0x1150/0x1460 at 16-cycle spacing; init_done rises with 4th wrt; no wrt before INT.
- Read, NUM_CH=2: raise INT; SPI model returns 0x34,0x12,0xCD,0xAB → cmds 0xA200,0xA300,0xAC00,0xAD00 at 16-cycle spacing; vld 64 cycles after first wrt; data = {0xABCD, 0x1234} (ch1 unfiltered).
- Filter: ch0 returns 0x1F01 → data[15:0]=0; 0x1F00 → 0x1F00; 0xE0FF (<-0x1F00) → 0; 0xE100 → 0xE100.
- Missing done: suppress done on slot 2 → spi_err set at that slot's GAP and stays set; byte retains prior value; vld still pulses.
- Timeout (INT_TO_W=8): hold INT low in WAIT → int_to=1 after 256 cycles; raise INT → int_to clears and read begins.
- Reset mid-read: assert rst_n low during slot 1 → all outputs 0 immediately; after release the init sequence replays from cycle 63.

Source files
------------

// File: rtl/inert_intf_mc.sv
// Multi-channel inertial sensor interface: runs the sensor init table, then on each
// data-ready reads NUM_CH 16-bit registers through SPI_mnrch, spike-filters and publishes them.
module inert_intf_mc #(
  parameter int                      NUM_CH      = 2,
  parameter logic [NUM_CH*8-1:0]     CH_ADDR     = {8'h2C, 8'h22},
  parameter int                      NUM_INIT    = 4,
  parameter logic [NUM_INIT*16-1:0]  INIT_CMDS   = {16'h1460, 16'h1150, 16'h1053, 16'h0D02},
  parameter int                      INIT_WAIT_W = 16,
  parameter int                      GAP_W       = 10,
  parameter int                      INT_TO_W    = 20,
  parameter logic [NUM_CH-1:0]       FILT_MASK   = NUM_CH'(1),
  parameter logic signed [15:0]      FILT_LIM    = 16'sh1F00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   INT,
  input  logic                   done,
  input  logic [15:0]            rd_data,
  output logic                   wrt,
  output logic [15:0]            cmd,
  output logic [NUM_CH*16-1:0]   data,
  output logic                   vld,
  output logic                   init_done,
  output logic                   spi_err,
  output logic                   int_to
);

  localparam int TW0 = (INIT_WAIT_W > GAP_W) ? INIT_WAIT_W : GAP_W;
  localparam int TW  = (TW0 > INT_TO_W) ? TW0 : INT_TO_W;
  localparam int NB  = 2 * NUM_CH;
  localparam int KW  = $clog2(NB);
  localparam int JW  = $clog2(NUM_INIT + 1);

  typedef enum logic [1:0] {PWR, INIT, WAIT, READ} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic [JW-1:0]   j, j_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic            int_ff1, int_ff2;
  logic            seen_done;
  logic            init_fin, err_set;
  logic [7:0]      byte_r [NB];
  logic            gap, pwr_exp, to_exp;
  logic            unused_hi;

  assign unused_hi = ^rd_data[15:8];

  assign gap     = &timer[GAP_W-1:0];
  assign pwr_exp = &timer[INIT_WAIT_W-1:0];
  assign to_exp  = &timer[INT_TO_W-1:0];

  // Read command for byte slot kk: even slots hit the low-byte address, odd slots addr+1.
  function automatic logic [15:0] rd_cmd(input int kk);
    logic [7:0] a;
    a = CH_ADDR[8*(kk/2) +: 8] + 8'(kk % 2);
    return {1'b1, a[6:0], 8'h00};
  endfunction

  function automatic logic [15:0] spike_filt(input logic signed [15:0] w, input logic en);
    if (en && ((w > FILT_LIM) || (w < -FILT_LIM)))
      return 16'h0000;
    return w;
  endfunction

  always_comb begin
    state_nxt = state;
    j_nxt     = j;
    k_nxt     = k;
    wrt       = 1'b0;
    cmd       = 16'h0000;
    vld       = 1'b0;
    init_fin  = 1'b0;
    err_set   = 1'b0;
    case (state)
      PWR: begin
        if (pwr_exp) begin
          wrt   = 1'b1;
          cmd   = INIT_CMDS[15:0];
          j_nxt = JW'(1);
          if (NUM_INIT == 1) begin
            init_fin  = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = INIT;
          end
        end
      end
      INIT: begin
        if (gap) begin
          wrt   = 1'b1;
          cmd   = INIT_CMDS[16*int'(j) +: 16];
          j_nxt = j + 1'b1;
          if (int'(j) == NUM_INIT - 1) begin
            init_fin  = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (int_ff2) begin
          wrt       = 1'b1;
          cmd       = rd_cmd(0);
          k_nxt     = '0;
          state_nxt = READ;
        end
      end
      READ: begin
        if (gap) begin
          // A done landing on the GAP cycle itself still counts for this slot.
          if (!(seen_done || done))
            err_set = 1'b1;
          if (int'(k) < NB - 1) begin
            wrt   = 1'b1;
            cmd   = rd_cmd(int'(k) + 1);
            k_nxt = k + 1'b1;
          end else begin
            vld       = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      default: state_nxt = PWR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWR;
      timer     <= '0;
      j         <= '0;
      k         <= '0;
      int_ff1   <= 1'b0;
      int_ff2   <= 1'b0;
      seen_done <= 1'b0;
      init_done <= 1'b0;
      spi_err   <= 1'b0;
      int_to    <= 1'b0;
      for (int b = 0; b < NB; b++)
        byte_r[b] <= 8'h00;
    end else begin
      state   <= state_nxt;
      j       <= j_nxt;
      k       <= k_nxt;
      int_ff1 <= INT;
      int_ff2 <= int_ff1;
      timer   <= wrt ? '0 : timer + 1'b1;
      if (wrt)
        seen_done <= 1'b0;
      else if (done)
        seen_done <= 1'b1;
      if (init_fin)
        init_done <= 1'b1;
      if (err_set)
        spi_err <= 1'b1;
      if (state == READ && done)
        byte_r[k] <= rd_data[7:0];
      // Timeout is measured from the last transaction, and only an INT seen in WAIT clears it.
      if (state == WAIT) begin
        if (int_ff2)
          int_to <= 1'b0;
        else if (to_exp)
          int_to <= 1'b1;
      end
    end
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < NUM_CH; i++)
      data[16*i +: 16] = spike_filt({byte_r[2*i+1], byte_r[2*i]}, FILT_MASK[i]);
  end

endmodule
